// File: rtl/dds_cfg_if.sv
// DDS configuration handshake: FTW/POW update request with valid/ready.
interface dds_cfg_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ACC_WIDTH-1:0] ftw_in;
    logic [ACC_WIDTH-1:0] pow_in;

    modport master (
        output cfg_valid, ftw_in, pow_in,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, ftw_in, pow_in,
        output cfg_ready
    );
endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator / NCO front end: FTW integration, phase offset,
// optional LFSR dither, truncation to the cosine ROM address.
module dds_phase_acc #(
    parameter int ACC_WIDTH      = 32,
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int UPD_ON_WRAP    = 1,
    parameter int DITHER_EN      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      phase_clr,
    dds_cfg_if.slave                  cfg,
    output logic [ROM_ADDR_WIDTH-1:0] addr,
    output logic                      wrap
);
    localparam int FW = ACC_WIDTH - ROM_ADDR_WIDTH;
    localparam int DW = (FW < 16) ? FW : 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [ACC_WIDTH-1:0] ftw_act, pow_act;
    logic [ACC_WIDTH-1:0] ftw_sh, pow_sh;
    logic [ACC_WIDTH-1:0] dith, sum;
    logic [15:0]          lfsr, lfsr_nxt;
    logic                 carry;
    logic                 accept, apply;

    assign {carry, acc_nxt} = {1'b0, acc} + {1'b0, ftw_act};
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign sum = acc + pow_act + dith;
    assign cfg.cfg_ready = (state == IDLE);

    always_comb begin
        dith = '0;
        if (DITHER_EN != 0)
            dith[DW-1:0] = lfsr[DW-1:0];
    end

    // An idle accumulator (ftw_act==0) never wraps, so it must not block updates.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        apply     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (ce && ((UPD_ON_WRAP == 0) || carry ||
                           (ftw_act == '0) || phase_clr)) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ftw_sh  <= '0;
            pow_sh  <= '0;
            ftw_act <= '0;
            pow_act <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ftw_sh <= cfg.ftw_in;
                pow_sh <= cfg.pow_in;
            end
            if (apply) begin
                ftw_act <= ftw_sh;
                pow_act <= pow_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            addr <= '0;
            wrap <= 1'b0;
            lfsr <= LFSR_SEED;
        end else if (ce) begin
            addr <= sum[ACC_WIDTH-1 -: ROM_ADDR_WIDTH];
            if (phase_clr) begin
                acc  <= '0;
                wrap <= 1'b0;
                lfsr <= LFSR_SEED;
            end else begin
                acc  <= acc_nxt;
                wrap <= carry;
                lfsr <= lfsr_nxt;
            end
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dds_phase_acc.sv
// Bench for dds_phase_acc: wrap-synchronous undithered instance and an
// immediate-update dithered instance against a behavioural model.
module tb_dds_phase_acc;
    localparam longint unsigned M32 = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        phase_clr;
    logic        valid;
    logic [31:0] ftw;
    logic [31:0] pow;
    logic [11:0] addr0, addr1;
    logic        wrap0, wrap1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dds_cfg_if #(.ACC_WIDTH(32)) cfg0 ();
    dds_cfg_if #(.ACC_WIDTH(32)) cfg1 ();

    assign cfg0.cfg_valid = valid;
    assign cfg0.ftw_in    = ftw;
    assign cfg0.pow_in    = pow;
    assign cfg1.cfg_valid = valid;
    assign cfg1.ftw_in    = ftw;
    assign cfg1.pow_in    = pow;

    dds_phase_acc #(
        .ACC_WIDTH(32), .ROM_ADDR_WIDTH(12),
        .UPD_ON_WRAP(1), .DITHER_EN(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .phase_clr(phase_clr),
        .cfg(cfg0), .addr(addr0), .wrap(wrap0)
    );

    dds_phase_acc #(
        .ACC_WIDTH(32), .ROM_ADDR_WIDTH(12),
        .UPD_ON_WRAP(0), .DITHER_EN(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .phase_clr(phase_clr),
        .cfg(cfg1), .addr(addr1), .wrap(wrap1)
    );

    typedef struct {
        longint unsigned acc, ftw, pow, sftw, spow;
        bit              pend;
        bit [15:0]       lfsr;
        int              addr;
        bit              wrap;
    } mstate_t;

    mstate_t m[2];

    function automatic mstate_t mreset();
        mstate_t r;
        r.acc = 0; r.ftw = 0; r.pow = 0; r.sftw = 0; r.spow = 0;
        r.pend = 0; r.lfsr = 16'hACE1; r.addr = 0; r.wrap = 0;
        return r;
    endfunction

    // Next state of one channel from the documented rules.
    function automatic mstate_t mstep(mstate_t s, bit upd_wrap, bit dith_en);
        mstate_t n = s;
        longint unsigned total = s.acc + s.ftw;
        bit carry = (total > M32);
        longint unsigned dith = dith_en ? longint'(s.lfsr) : 0;
        if (ce) begin
            n.addr = int'(((s.acc + s.pow + dith) & M32) >> 20);
            if (phase_clr) begin
                n.acc = 0; n.wrap = 0; n.lfsr = 16'hACE1;
            end else begin
                n.acc  = total & M32;
                n.wrap = carry;
                n.lfsr = {^(s.lfsr & 16'h002D), s.lfsr[15:1]};
            end
        end else begin
            n.wrap = 0;
        end
        if (s.pend && ce && (!upd_wrap || carry || s.ftw == 0 || phase_clr)) begin
            n.ftw = s.sftw; n.pow = s.spow; n.pend = 0;
        end
        if (!s.pend && valid) begin
            n.sftw = ftw; n.spow = pow; n.pend = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= mreset();
            m[1] <= mreset();
        end else begin
            m[0] <= mstep(m[0], 1'b1, 1'b0);
            m[1] <= mstep(m[1], 1'b0, 1'b1);
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("addr0", int'(addr0), m[0].addr);
        chk("wrap0", int'(wrap0), int'(m[0].wrap));
        chk("ready0", int'(cfg0.cfg_ready), int'(!m[0].pend));
        chk("addr1", int'(addr1), m[1].addr);
        chk("wrap1", int'(wrap1), int'(m[1].wrap));
        chk("ready1", int'(cfg1.cfg_ready), int'(!m[1].pend));
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [31:0] f, logic [31:0] p);
        int i = 0;
        while (!cfg0.cfg_ready && i < 10000) begin
            tick(1);
            i++;
        end
        chk("wait_ready", int'(cfg0.cfg_ready), 1);
        valid = 1'b1; ftw = f; pow = p;
        tick(1);
        valid = 1'b0;
    endtask

    task automatic wait_addr(int target);
        int i = 0;
        while (int'(addr0) != target && i < 10000) begin
            tick(1);
            i++;
        end
        chk("wait_addr", int'(addr0), target);
    endtask

    initial begin
        int cnt, a0, a1, a2, a3;
        rst_n = 1'b0; ce = 1'b1; phase_clr = 1'b0;
        valid = 1'b0; ftw = 32'd5; pow = 32'd0;

        // reset
        tick(3);
        chk("rst_addr", int'(addr0), 0);
        chk("rst_wrap", int'(wrap0), 0);
        chk("rst_ready", int'(cfg0.cfg_ready), 1);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_addr", int'(addr0), 0);

        // ramp: two wraps in any 8192-cycle window
        send(32'h0010_0000, 32'h0);
        tick(2);
        cnt = 0;
        for (int i = 0; i < 8192; i++) begin
            tick(1);
            if (wrap0) cnt++;
        end
        chk("ramp_wraps", cnt, 2);

        // wrap-synchronous update
        send(32'h4000_0000, 32'h0);
        send(32'h2000_0000, 32'h0);
        chk("sync_pending", int'(cfg0.cfg_ready), 0);
        cnt = 0;
        while (!wrap0 && cnt < 10000) begin
            tick(1);
            cnt++;
        end
        chk("wait_wrap", int'(wrap0), 1);
        a0 = int'(addr0); tick(1);
        a1 = int'(addr0); tick(1);
        a2 = int'(addr0); tick(1);
        a3 = int'(addr0);
        chk("sync_d1", (a1 - a0) & 4095, 1024);
        chk("sync_d2", (a2 - a1) & 4095, 512);
        chk("sync_d3", (a3 - a2) & 4095, 512);
        chk("sync_ready", int'(cfg0.cfg_ready), 1);

        // asynchronous reset mid-operation
        #1 rst_n = 1'b0;
        #1 chk("async_addr", int'(addr0), 0);
        chk("async_ready", int'(cfg0.cfg_ready), 1);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // phase offset with ftw=0
        send(32'h0, 32'h4000_0000);
        tick(4);
        for (int i = 0; i < 3; i++) begin
            chk("pow_addr", int'(addr0), 1024);
            tick(1);
        end

        // clock-enable gating
        send(32'h0010_0000, 32'h0);
        tick(3);
        for (int i = 0; i < 2100; i++) begin
            a0 = int'(addr0);
            ce = 1'b1; tick(1);
            ce = 1'b0; tick(1);
            tick(1);
            ce = 1'b1; tick(1);
            chk("ce_step", (int'(addr0) - a0) & 4095, 2);
        end

        // phase clear at acc=0x8000_0000 with a pending update
        wait_addr(2045);
        valid = 1'b1; ftw = 32'h0020_0000; pow = 32'h0;
        tick(1);
        valid = 1'b0;
        chk("clr_pending", int'(cfg0.cfg_ready), 0);
        tick(1);
        chk("clr_pre", int'(addr0), 2047);
        phase_clr = 1'b1;
        tick(1);
        phase_clr = 1'b0;
        chk("clr_old_acc", int'(addr0), 2048);
        chk("clr_wrap", int'(wrap0), 0);
        chk("clr_applied", int'(cfg0.cfg_ready), 1);
        tick(1);
        chk("clr_zero", int'(addr0), 0);
        tick(1);
        chk("clr_resume", int'(addr0), 2);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
